// File: rtl/boot_load_sequencer.sv
// Boot image loader: streams words into instruction memory, reads them back to
// confirm the running checksum, then releases the CPU.
module boot_load_sequencer #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              truncated,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    // Index of the last word that fits in memory (DEPTH - 1)
    localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_RUN,
        S_ERROR
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] rd_idx_q;
    logic [31:0]      vsum_q;
    logic             rd_pend_q;

    logic handshake;
    logic final_word;
    logic begin_load;

    function automatic logic [63:0] byte_addr(input logic [ADDR_W-1:0] idx);
        return 64'({idx, 2'b00});
    endfunction

    assign handshake  = (state_q == S_LOAD) && load_valid && load_ready && !abort;
    assign final_word = load_last || (word_count == LAST_IDX);
    assign begin_load = start && !abort && ((state_q == S_IDLE) || (state_q == S_ERROR));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            vsum_q     <= '0;
            rd_pend_q  <= 1'b0;
            load_ready <= 1'b0;
            addr_ext   <= '0;
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            wdata_ext  <= '0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            truncated  <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            wen_ext   <= 1'b0;
            ren_ext   <= 1'b0;
            // Read data returns the cycle after the strobe
            rd_pend_q <= ren_ext;
            if (abort) begin
                state_q    <= S_IDLE;
                load_ready <= 1'b0;
                cpu_enable <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
                rd_pend_q  <= 1'b0;
            end else if (begin_load) begin
                state_q    <= S_LOAD;
                load_ready <= 1'b1;
                busy       <= 1'b1;
                word_count <= '0;
                checksum   <= '0;
                truncated  <= 1'b0;
                error      <= 1'b0;
                rd_idx_q   <= '0;
                vsum_q     <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (handshake) begin
                            wen_ext    <= 1'b1;
                            addr_ext   <= byte_addr(word_count[ADDR_W-1:0]);
                            wdata_ext  <= load_data;
                            word_count <= word_count + CNT_W'(1);
                            checksum   <= checksum + load_data;
                            if (final_word) begin
                                load_ready <= 1'b0;
                                truncated  <= !load_last;
                                state_q    <= S_VERIFY;
                            end
                        end
                    end
                    S_VERIFY: begin
                        if (rd_pend_q) begin
                            vsum_q <= vsum_q + rdata_ext;
                        end
                        if (rd_idx_q < word_count) begin
                            ren_ext  <= 1'b1;
                            addr_ext <= byte_addr(rd_idx_q[ADDR_W-1:0]);
                            rd_idx_q <= rd_idx_q + CNT_W'(1);
                        end else if (!ren_ext && !rd_pend_q) begin
                            // All read data accumulated: decide
                            busy <= 1'b0;
                            if (vsum_q == checksum) begin
                                state_q    <= S_RUN;
                                cpu_enable <= 1'b1;
                                done       <= 1'b1;
                            end else begin
                                state_q <= S_ERROR;
                                error   <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
